// File: rtl/cpu_dm_master_pkg.sv
// Shared AXI constants and the data-memory port state type for cpu_dm_master.
package cpu_axi_pkg;

    typedef enum logic [2:0] {
        DM_IDLE  = 3'd0,
        DM_RADDR = 3'd1,
        DM_RDATA = 3'd2,
        DM_WADDR = 3'd3,
        DM_WRESP = 3'd4,
        DM_DONE  = 3'd5
    } dm_state_t;

    localparam logic [1:0]  AXI_BURST_INCR = 2'b01;
    localparam logic [2:0]  AXI_SIZE_WORD  = 3'b010;
    localparam logic [1:0]  AXI_RESP_OKAY  = 2'b00;
    localparam logic [31:0] DM_BAD_DATA    = 32'hDEAD_BEEF;

    function automatic logic resp_is_err(input logic [1:0] resp);
        return resp != AXI_RESP_OKAY;
    endfunction

endpackage

// File: rtl/cpu_dm_master_if.sv
// AXI4 master port (M1) used by the CPU data-memory port; single-beat transfers only.
// Every channel transfers on the rising edge where VALID and READY are both high; once raised,
// VALID and its payload stay stable until that edge, and READY may be driven independently of VALID.
interface cpu_dm_master_if #(
    parameter int ID_W = 4
);
    logic [ID_W-1:0] ARID;
    logic [31:0]     ARADDR;
    logic [7:0]      ARLEN;
    logic [2:0]      ARSIZE;
    logic [1:0]      ARBURST;
    logic            ARVALID;
    logic            ARREADY;
    logic [ID_W-1:0] RID;
    logic [31:0]     RDATA;
    logic [1:0]      RRESP;
    logic            RLAST;
    logic            RVALID;
    logic            RREADY;
    logic [ID_W-1:0] AWID;
    logic [31:0]     AWADDR;
    logic [7:0]      AWLEN;
    logic [2:0]      AWSIZE;
    logic [1:0]      AWBURST;
    logic            AWVALID;
    logic            AWREADY;
    logic [31:0]     WDATA;
    logic [3:0]      WSTRB;
    logic            WLAST;
    logic            WVALID;
    logic            WREADY;
    logic [ID_W-1:0] BID;
    logic [1:0]      BRESP;
    logic            BVALID;
    logic            BREADY;

    modport master (
        output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, RREADY,
        output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        output WDATA, WSTRB, WLAST, WVALID, BREADY,
        input  ARREADY, RID, RDATA, RRESP, RLAST, RVALID,
        input  AWREADY, WREADY, BID, BRESP, BVALID
    );

    modport slave (
        input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, RREADY,
        input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        input  WDATA, WSTRB, WLAST, WVALID, BREADY,
        output ARREADY, RID, RDATA, RRESP, RLAST, RVALID,
        output AWREADY, WREADY, BID, BRESP, BVALID
    );

endinterface

// File: rtl/cpu_dm_master_watchdog.sv
// Transfer watchdog for cpu_dm_master: counts busy cycles, restarts on i_clr, flags expiry at TIMEOUT-1.
module dm_watchdog #(
    parameter int TIMEOUT = 256
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_run,
    input  logic i_clr,
    output logic o_expire
);
    localparam int CW = ($clog2(TIMEOUT) < 8) ? 8 : $clog2(TIMEOUT);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_run && !o_expire) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign o_expire = i_run && (r_cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/cpu_dm_master.sv
// CPU data-memory port: one single-beat AXI4 read or write per MEM-stage request, stalling the pipeline until done.
// Build option DM_TIMEOUT_EN adds a watchdog that aborts a hung transfer with dm_err and dm_rdata=DEAD_BEEF.
module cpu_dm_master
    import cpu_axi_pkg::*;
#(
    parameter int              ID_W    = 4,
    parameter logic [ID_W-1:0] MID     = ID_W'(1),
    parameter int              TIMEOUT = 256
) (
    input  logic                   ACLK,
    input  logic                   ARESETn,
    input  logic                   dm_req,
    input  logic                   dm_we,
    input  logic [31:0]            dm_addr,
    input  logic [31:0]            dm_wdata,
    input  logic [3:0]             dm_wstrb,
    input  logic                   mem_advance,
    output logic                   DM_stall,
    output logic [31:0]            dm_rdata,
    output logic                   dm_err,
    output dm_state_t              o_dbg_state,
    cpu_dm_master_if.master        m_axi
);
    localparam logic [2:0] S_IDLE  = DM_IDLE;
    localparam logic [2:0] S_RADDR = DM_RADDR;
    localparam logic [2:0] S_RDATA = DM_RDATA;
    localparam logic [2:0] S_WADDR = DM_WADDR;
    localparam logic [2:0] S_WRESP = DM_WRESP;
    localparam logic [2:0] S_DONE  = DM_DONE;

    logic [2:0]  r_state, w_next;
    logic        r_aw_done, r_w_done;
    logic [31:0] r_addr, r_wdata, r_rdata;
    logic [3:0]  r_wstrb;
    logic        r_err;
    logic        w_busy, w_expire;
    logic        w_arvalid, w_rready, w_awvalid, w_wvalid, w_bready;
    logic        w_r_hs, w_b_hs, w_aw_ok, w_w_ok;
    logic        w_unused;

    assign w_busy    = (r_state == S_RADDR) || (r_state == S_RDATA) ||
                       (r_state == S_WADDR) || (r_state == S_WRESP);
    assign w_arvalid = (r_state == S_RADDR);
    assign w_rready  = (r_state == S_RDATA);
    assign w_awvalid = (r_state == S_WADDR) && !r_aw_done;
    assign w_wvalid  = (r_state == S_WADDR) && !r_w_done;
    assign w_bready  = (r_state == S_WRESP);

    assign w_r_hs  = w_rready && m_axi.RVALID;
    assign w_b_hs  = w_bready && m_axi.BVALID;
    // AW and W complete independently; "ok" means done earlier or handshaking this edge.
    assign w_aw_ok = r_aw_done || (w_awvalid && m_axi.AWREADY);
    assign w_w_ok  = r_w_done  || (w_wvalid  && m_axi.WREADY);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (dm_req)              w_next = dm_we ? S_WADDR : S_RADDR;
            S_RADDR: if (m_axi.ARREADY)       w_next = S_RDATA;
            S_RDATA: if (m_axi.RVALID)        w_next = S_DONE;
            S_WADDR: if (w_aw_ok && w_w_ok)   w_next = S_WRESP;
            S_WRESP: if (m_axi.BVALID)        w_next = S_DONE;
            S_DONE:  if (mem_advance)         w_next = S_IDLE;
            default:                          w_next = S_IDLE;
        endcase
        if (w_expire) begin
            w_next = S_DONE;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_state   <= S_IDLE;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_rdata   <= '0;
            r_err     <= 1'b0;
        end else begin
            r_state <= w_next;
            r_err   <= 1'b0;
            if ((r_state == S_IDLE) && dm_req) begin
                r_addr  <= dm_addr;
                r_wdata <= dm_wdata;
                r_wstrb <= dm_wstrb;
            end
            if (w_expire) begin
                r_err   <= 1'b1;
                r_rdata <= DM_BAD_DATA;
            end else if (w_r_hs) begin
                r_rdata <= m_axi.RDATA;
                r_err   <= resp_is_err(m_axi.RRESP);
            end else if (w_b_hs) begin
                r_err   <= resp_is_err(m_axi.BRESP);
            end
            if ((r_state == S_WADDR) && (w_next == S_WADDR)) begin
                r_aw_done <= w_aw_ok;
                r_w_done  <= w_w_ok;
            end else begin
                r_aw_done <= 1'b0;
                r_w_done  <= 1'b0;
            end
        end
    end

`ifdef DM_TIMEOUT_EN
    logic w_wd_clr;
    // Restart the count on every state entry so each phase gets the full budget.
    assign w_wd_clr = !w_busy || (w_next != r_state);

    dm_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .i_clk    (ACLK),
        .i_rst_n  (ARESETn),
        .i_run    (w_busy),
        .i_clr    (w_wd_clr),
        .o_expire (w_expire)
    );
`else
    assign w_expire = 1'b0;
`endif

    assign m_axi.ARID    = MID;
    assign m_axi.ARADDR  = r_addr;
    assign m_axi.ARLEN   = 8'd0;
    assign m_axi.ARSIZE  = AXI_SIZE_WORD;
    assign m_axi.ARBURST = AXI_BURST_INCR;
    assign m_axi.ARVALID = w_arvalid;
    assign m_axi.RREADY  = w_rready;
    assign m_axi.AWID    = MID;
    assign m_axi.AWADDR  = r_addr;
    assign m_axi.AWLEN   = 8'd0;
    assign m_axi.AWSIZE  = AXI_SIZE_WORD;
    assign m_axi.AWBURST = AXI_BURST_INCR;
    assign m_axi.AWVALID = w_awvalid;
    assign m_axi.WDATA   = r_wdata;
    assign m_axi.WSTRB   = r_wstrb;
    assign m_axi.WLAST   = 1'b1;
    assign m_axi.WVALID  = w_wvalid;
    assign m_axi.BREADY  = w_bready;

    // The request cycle itself stalls; DONE releases the pipeline while data is held.
    assign DM_stall    = (r_state == S_IDLE) ? dm_req : w_busy;
    assign dm_rdata    = r_rdata;
    assign dm_err      = r_err;
    assign o_dbg_state = dm_state_t'(r_state);

    assign w_unused = ^{m_axi.RID, m_axi.RLAST, m_axi.BID, TIMEOUT[0]};

endmodule

// File: tb/tb_cpu_dm_master.sv
// Bench for cpu_dm_master: randomized loads/stores against a reactive AXI slave and a word-memory reference model.
// Define DM_TIMEOUT_EN to also exercise the watchdog abort with TIMEOUT=16.
module tb_cpu_dm_master;
    import cpu_axi_pkg::*;

`ifdef DM_TIMEOUT_EN
    localparam int TB_TIMEOUT = 16;
`else
    localparam int TB_TIMEOUT = 256;
`endif
    localparam logic [31:0] BASE = 32'h0001_0000;

    logic        ACLK;
    logic        ARESETn;
    logic        dm_req, dm_we, mem_advance;
    logic [31:0] dm_addr, dm_wdata;
    logic [3:0]  dm_wstrb;
    logic        DM_stall, dm_err;
    logic [31:0] dm_rdata;
    dm_state_t   dbg_state;

    cpu_dm_master_if #(.ID_W(4)) axi ();

    cpu_dm_master #(
        .ID_W    (4),
        .MID     (4'd1),
        .TIMEOUT (TB_TIMEOUT)
    ) dut (
        .ACLK        (ACLK),
        .ARESETn     (ARESETn),
        .dm_req      (dm_req),
        .dm_we       (dm_we),
        .dm_addr     (dm_addr),
        .dm_wdata    (dm_wdata),
        .dm_wstrb    (dm_wstrb),
        .mem_advance (mem_advance),
        .DM_stall    (DM_stall),
        .dm_rdata    (dm_rdata),
        .dm_err      (dm_err),
        .o_dbg_state (dbg_state),
        .m_axi       (axi)
    );

    // ---------------- clock / reset ----------------
    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    // ---------------- scoreboard state ----------------
    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_q[$];
    logic [31:0] ref_mem [8];
    logic [31:0] slv_mem [8];
    logic [31:0] ar_q[$];
    logic [31:0] aw_q[$];
    logic [36:0] w_q[$];
    int          viol = 0;

    // slave knobs: AR/AW accept delay, W accept delay, R/B response delay
    int          cfg_a = 0, cfg_w = 0, cfg_d = 0;
    logic [1:0]  cfg_resp = 2'b00;

    int          ar_cnt, aw_cnt, w_cnt, r_cnt, b_cnt;
    logic        rd_pend, aw_got, w_got;
    logic [2:0]  rd_k, wr_k;
    logic [31:0] wr_d;
    logic [3:0]  wr_s;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] ws);
        logic [31:0] m;
        m = old;
        for (int b = 0; b < 4; b++) if (ws[b]) m[8*b +: 8] = wd[8*b +: 8];
        return m;
    endfunction

    // ---------------- reactive AXI slave (drives on negedge) ----------------
    always @(negedge ACLK) begin
        if (!ARESETn) begin
            axi.ARREADY = 1'b0; axi.RVALID = 1'b0; axi.AWREADY = 1'b0;
            axi.WREADY  = 1'b0; axi.BVALID = 1'b0;
            axi.RID = 4'd1; axi.BID = 4'd1; axi.RLAST = 1'b1;
            axi.RDATA = '0; axi.RRESP = 2'b00; axi.BRESP = 2'b00;
            rd_pend = 1'b0; aw_got = 1'b0; w_got = 1'b0;
            ar_cnt = 0; aw_cnt = 0; w_cnt = 0; r_cnt = 0; b_cnt = 0;
        end else begin
            if (axi.RVALID) begin
                axi.RVALID = 1'b0;
                if (axi.RREADY) viol++;
            end else if (rd_pend) begin
                if (r_cnt == cfg_d) begin
                    axi.RVALID = 1'b1; axi.RDATA = slv_mem[rd_k]; axi.RRESP = cfg_resp;
                    rd_pend = 1'b0; r_cnt = 0;
                end else r_cnt++;
            end
            if (axi.ARREADY) begin
                axi.ARREADY = 1'b0;
                if (axi.ARVALID) viol++;
            end else if (axi.ARVALID) begin
                if (ar_cnt == cfg_a) begin
                    axi.ARREADY = 1'b1; ar_q.push_back(axi.ARADDR);
                    rd_k = axi.ARADDR[4:2]; rd_pend = 1'b1; ar_cnt = 0;
                end else ar_cnt++;
            end else ar_cnt = 0;
            if (axi.BVALID) begin
                axi.BVALID = 1'b0;
                if (axi.BREADY) viol++;
            end else if (aw_got && w_got) begin
                if (b_cnt == cfg_d) begin
                    axi.BVALID = 1'b1; axi.BRESP = cfg_resp;
                    if (cfg_resp == 2'b00) slv_mem[wr_k] = merge(slv_mem[wr_k], wr_d, wr_s);
                    aw_got = 1'b0; w_got = 1'b0; b_cnt = 0;
                end else b_cnt++;
            end
            if (axi.AWREADY) begin
                axi.AWREADY = 1'b0;
                if (axi.AWVALID) viol++;
            end else if (axi.AWVALID) begin
                if (aw_cnt == cfg_a) begin
                    axi.AWREADY = 1'b1; aw_q.push_back(axi.AWADDR);
                    wr_k = axi.AWADDR[4:2]; aw_got = 1'b1; aw_cnt = 0;
                end else aw_cnt++;
            end else aw_cnt = 0;
            if (axi.WREADY) begin
                axi.WREADY = 1'b0;
                if (axi.WVALID) viol++;
            end else if (axi.WVALID) begin
                if (w_cnt == cfg_w) begin
                    axi.WREADY = 1'b1; w_q.push_back({axi.WLAST, axi.WSTRB, axi.WDATA});
                    wr_d = axi.WDATA; wr_s = axi.WSTRB; w_got = 1'b1; w_cnt = 0;
                end else w_cnt++;
            end else w_cnt = 0;
        end
    end

    // ---------------- driver: one request through DONE and advance ----------------
    task automatic run_txn(input logic we, input logic [2:0] k, input logic [31:0] wd,
                           input logic [3:0] ws, input int hold, input bit to);
        logic [31:0] addr, exp_rd;
        int          exp_stall, stalls, errs, cyc;
        bit          exp_err;
        addr    = BASE + {27'd0, k, 2'b00};
        exp_err = to || (cfg_resp != 2'b00);
        if (to)      exp_stall = 1 + TB_TIMEOUT;
        else if (we) exp_stall = 3 + ((cfg_a > cfg_w) ? cfg_a : cfg_w) + cfg_d;
        else         exp_stall = 3 + cfg_a + cfg_d;
        if (!we) exp_q.push_back(to ? 32'hDEAD_BEEF : ref_mem[k]);
        ar_q.delete(); aw_q.delete(); w_q.delete();
        dm_req = 1'b1; dm_we = we; dm_addr = addr; dm_wdata = wd; dm_wstrb = ws; mem_advance = 1'b0;
        #1;
        stalls = 0; errs = 0; cyc = 0;
        while (DM_stall === 1'b1 && cyc < 300) begin
            stalls++;
            if (dm_err) errs++;
            @(negedge ACLK); #1;
            cyc++;
        end
        check("stall_cycles", stalls, exp_stall);
        exp_rd = we ? 32'h0 : exp_q.pop_front();
        for (int i = 0; i <= hold; i++) begin
            check("done_stall", DM_stall, 0);
            if (!we) check("rdata", dm_rdata, exp_rd);
            if (dm_err) errs++;
            if (i == hold) mem_advance = 1'b1;
            @(negedge ACLK); #1;
        end
        dm_req = 1'b0; mem_advance = 1'b0;
        if (dm_err) errs++;
        check("err_pulses", errs, exp_err);
        check("proto_viol", viol, 0);
        if (we) begin
            check("aw_count", aw_q.size(), 1);
            check("w_count", w_q.size(), 1);
            if (aw_q.size() > 0) check("awaddr", aw_q[0], addr);
            if (w_q.size() > 0)  check("wbeat", w_q[0], {1'b1, ws, wd});
            if (cfg_resp == 2'b00) ref_mem[k] = merge(ref_mem[k], wd, ws);
        end else begin
            check("ar_count", ar_q.size(), to ? 0 : 1);
            if (ar_q.size() > 0) check("araddr", ar_q[0], addr);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int cyc;
        logic [31:0] v;
        ARESETn = 1'b0; dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0;
        dm_wdata = '0; dm_wstrb = '0; mem_advance = 1'b0;
        for (int k = 0; k < 8; k++) begin
            v = $urandom;
            ref_mem[k] = v; slv_mem[k] = v;
        end
        ref_mem[1] = 32'h1234_5678; slv_mem[1] = 32'h1234_5678;
        repeat (3) @(negedge ACLK);
        #1;
        check("rst_valids", {axi.ARVALID, axi.RREADY, axi.AWVALID, axi.WVALID, axi.BREADY}, 0);
        check("rst_stall", DM_stall, 0);
        check("rst_rdata", dm_rdata, 0);
        check("rst_err", dm_err, 0);
        check("rst_state", dbg_state, DM_IDLE);
        ARESETn = 1'b1;
        @(negedge ACLK); #1;

        // load from 0x0001_0004, always-ready slave
        cfg_a = 0; cfg_w = 0; cfg_d = 0; cfg_resp = 2'b00;
        run_txn(1'b0, 3'd1, 32'h0, 4'h0, 0, 1'b0);
        // store with WREADY 4 cycles after AWREADY, low half-word strobes, then read back
        cfg_w = 4;
        run_txn(1'b1, 3'd2, 32'hCAFE_F00D, 4'b0011, 0, 1'b0);
        cfg_w = 0;
        run_txn(1'b0, 3'd2, 32'h0, 4'h0, 0, 1'b0);
        // load held in DONE for 5 cycles
        run_txn(1'b0, 3'd5, 32'h0, 4'h0, 5, 1'b0);
        // SLVERR on read: error pulse, data still captured
        cfg_resp = 2'b10;
        run_txn(1'b0, 3'd4, 32'h0, 4'h0, 2, 1'b0);
        cfg_resp = 2'b00;

        // reset while waiting in the read-data phase
        cfg_d = 6;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = BASE + 32'd12; mem_advance = 1'b0;
        cyc = 0;
        #1;
        while (axi.RREADY !== 1'b1 && cyc < 20) begin
            @(negedge ACLK); #1;
            cyc++;
        end
        check("reach_rdata", axi.RREADY, 1);
        ARESETn = 1'b0; dm_req = 1'b0;
        #1;
        check("arst_valids", {axi.ARVALID, axi.RREADY, axi.AWVALID, axi.WVALID, axi.BREADY}, 0);
        check("arst_stall", DM_stall, 0);
        check("arst_rdata", dm_rdata, 0);
        repeat (2) @(negedge ACLK);
        #1;
        ARESETn = 1'b1;
        cfg_d = 0;
        @(negedge ACLK); #1;
        run_txn(1'b0, 3'd3, 32'h0, 4'h0, 0, 1'b0);

`ifdef DM_TIMEOUT_EN
        // slave never accepts the read address
        cfg_a = 1000;
        run_txn(1'b0, 3'd6, 32'h0, 4'h0, 1, 1'b1);
        cfg_a = 0;
`endif

        // randomized mix of loads and stores
        for (int t = 0; t < 40; t++) begin
            cfg_a    = $urandom_range(0, 3);
            cfg_w    = $urandom_range(0, 3);
            cfg_d    = $urandom_range(0, 3);
            cfg_resp = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            run_txn(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom,
                    4'($urandom_range(1, 15)), $urandom_range(0, 3), 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cpu_dm_master.md
Name: cpu_dm_master

Overview:
CPU-side data-memory port: turns the MEM-stage load/store request into one single-beat AXI4 read or write, and drives DM_stall into the pipeline hazard unit until that transfer completes. It is the producer side of the stall handshake that the hazard unit consumes. It sits between the CPU MEM stage and AXI master port M1.

Parameters:
ID_W, 4, AXI ID width
MID, 4'd1, constant ID driven on ARID/AWID
TIMEOUT, 256, watchdog limit in cycles (used only with DM_TIMEOUT_EN)

Ports:
ACLK  in  1  clock
ARESETn  in  1  asynchronous active-low reset
dm_req  in  1  MEM stage holds a load or store
dm_we  in  1  1 = store, 0 = load
dm_addr  in  32  byte address, word-aligned
dm_wdata  in  32  store data
dm_wstrb  in  4  active-high byte strobes
mem_advance  in  1  pipeline advances this edge (MEM_WB_regwrite)
DM_stall  out  1  hold the pipeline
dm_rdata  out  32  load data, held until advance
dm_err  out  1  one-cycle pulse on SLVERR/DECERR (or timeout)
ARID/ARADDR/ARVALID  out  ID_W/32/1  read address; ARLEN=0, ARSIZE=3'b010, ARBURST=INCR are constants
ARREADY  in  1  read address accept
RID/RDATA/RRESP/RLAST/RVALID  in  ID_W/32/2/1/1  read data
RREADY  out  1  read data accept
AWID/AWADDR/AWVALID  out  ID_W/32/1  write address; AWLEN/AWSIZE/AWBURST as for AR
AWREADY  in  1
WDATA/WSTRB/WLAST/WVALID  out  32/4/1/1  WLAST tied to 1
WREADY  in  1
BID/BRESP/BVALID  in  ID_W/2/1
BREADY  out  1

Behaviour:
- Reset (async, ARESETn=0): state=IDLE, all VALID/READY=0, dm_rdata=0, dm_err=0, flags cleared. DM_stall=0 while dm_req=0. Reset mid-transfer abandons the transfer immediately.
- FSM states: IDLE, RADDR, RDATA, WADDR, WRESP, DONE.
- IDLE:
  - dm_req&!dm_we -> RADDR.
  - dm_req&dm_we -> WADDR.
  - DM_stall = dm_req (combinational), so the request cycle already stalls.
- RADDR: ARVALID=1, ARADDR=dm_addr. On ARREADY -> RDATA. ARVALID never drops before the handshake.
- RDATA: RREADY=1. On RVALID, capture RDATA into dm_rdata, pulse dm_err if RRESP!=0, then -> DONE.
- WADDR: AWVALID and WVALID are raised together. Each drops after its own handshake (aw_done/w_done flags). Move to WRESP in the cycle both are done; both may complete in the same cycle.
- WRESP: BREADY=1. On BVALID, pulse dm_err if BRESP!=0, then -> DONE.
- DM_stall = 1 in RADDR, RDATA, WADDR and WRESP, and 0 in DONE.
- Minimum latency with always-ready slave:
  - load: 3 stalled cycles (IDLE, RADDR, RDATA).
  - store: 3 stalled cycles (IDLE, WADDR, WRESP).
- DONE: dm_rdata is held stable. The same request must not be reissued while another stall (IM_stall) freezes the pipeline. On mem_advance=1 -> IDLE; a new dm_req is accepted on the following cycle.
- dm_req=0 in IDLE: no bus activity. dm_req dropping mid-transfer is illegal (protocol error, no defined recovery).
- RID/BID are ignored; a single transaction is ever outstanding.

Optional Feature:
DM_TIMEOUT_EN:
- Defined: an 8+ bit counter runs in RADDR/RDATA/WADDR/WRESP and reloads on each state entry. On reaching TIMEOUT-1 it drops all VALID/READY, pulses dm_err, sets dm_rdata=32'hDEAD_BEEF, and goes -> DONE.
- Undefined: no counter; the block waits indefinitely.

Decomposition:
- Package cpu_axi_pkg holds:
  - state enum dm_state_t;
  - constants AXI_BURST_INCR=2'b01, AXI_SIZE_WORD=3'b010, AXI_RESP_OKAY=2'b00;
  - localparam DM_BAD_DATA=32'hDEAD_BEEF.
- One optional sub-module, dm_watchdog (counter, clear and expire), instantiated only under DM_TIMEOUT_EN. The FSM and channel logic stay flat.

Test Plan:
- Load, slave always ready, addr 0x0001_0004, RDATA 0x1234_5678 -> DM_stall high for 3 cycles, ARADDR matches, dm_rdata=0x1234_5678 in DONE, dm_err=0.
- Store with WREADY delayed 4 cycles after AWREADY, wstrb 4'b0011 -> AWVALID drops after 1 cycle, WVALID holds until WREADY, DM_stall clears only after BVALID.
- Load completes while mem_advance is held 0 for 5 cycles -> exactly one AR handshake, dm_rdata stable, DM_stall=0 throughout DONE.
- RRESP=2'b10 -> dm_err pulses exactly 1 cycle and data is still captured.
- ARESETn asserted during RDATA -> all VALID/READY go low asynchronously; next dm_req starts a fresh AR.
- With DM_TIMEOUT_EN, TIMEOUT=16, ARREADY never asserted -> after 16 cycles ARVALID=0, dm_err pulse, dm_rdata=0xDEAD_BEEF, DM_stall=0.
